// File: rtl/bwn_conv3x3_if.sv
// Stream, weight and result signals of the bwn_conv3x3 stage, grouped for port connection.
// master drives the pixel stream and taps; slave is the convolution stage.
interface bwn_conv3x3_if #(
  parameter int WL  = 8,
  parameter int OWL = WL + 5
);
  logic                  iEN;
  logic                  iSTART;
  logic [WL-1:0]         iDATA;
  logic [WL-1:0]         iTAP1;
  logic [WL-1:0]         iTAP2;
  logic [8:0]            iWEIGHT;
  logic signed [OWL-1:0] oSUM;
  logic                  oVALID;
  logic                  oFRAME_DONE;

  modport master (
    output iEN, iSTART, iDATA, iTAP1, iTAP2, iWEIGHT,
    input  oSUM, oVALID, oFRAME_DONE
  );

  modport slave (
    input  iEN, iSTART, iDATA, iTAP1, iTAP2, iWEIGHT,
    output oSUM, oVALID, oFRAME_DONE
  );
endinterface

// File: rtl/bwn_conv3x3.sv
// Binary-weight 3x3 convolution over a raster stream plus two line-buffer taps; 3-stage pipeline.
// Optional macro BWN_RELU_EN clamps negative window sums to zero in the output stage.
module bwn_conv3x3 #(
  parameter int WL     = 8,
  parameter int WIDTH  = 17,
  parameter int HEIGHT = 17,
  parameter int OWL    = WL + 5
) (
  input logic          iCLK,
  input logic          iRSTn,
  bwn_conv3x3_if.slave bus
);
  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int SW = WL + 3;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);

  logic [8:0]            weight;
  logic [WL-1:0]         win [3][3];
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  win_ok;
  logic                  win_last;
  logic signed [SW-1:0]  row_sum [3];
  logic signed [SW-1:0]  row_sum_q [3];
  logic                  sum_ok;
  logic                  sum_last;
  logic signed [OWL-1:0] total;
  logic signed [OWL-1:0] total_out;

  function automatic logic signed [SW-1:0] term(input logic [WL-1:0] p, input logic w);
    logic signed [SW-1:0] e;
    e = $signed({3'b000, p});
    return w ? e : -e;
  endfunction

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn)
      weight <= '0;
    else if (bus.iSTART)
      weight <= bus.iWEIGHT;
  end

  // Stage 1: window shift, raster position and the interior-window flag.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
      col      <= '0;
      row      <= '0;
      win_ok   <= 1'b0;
      win_last <= 1'b0;
    end else if (bus.iSTART) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
      col      <= '0;
      row      <= '0;
      win_ok   <= 1'b0;
      win_last <= 1'b0;
    end else begin
      win_ok   <= bus.iEN && (col >= COL_MIN) && (row >= ROW_MIN);
      win_last <= bus.iEN && (col == COL_LAST) && (row == ROW_LAST);
      if (bus.iEN) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= bus.iTAP2;
        win[1][2] <= bus.iTAP1;
        win[2][2] <= bus.iDATA;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++)
      row_sum[r] = term(win[r][0], weight[3*r])
                 + term(win[r][1], weight[3*r+1])
                 + term(win[r][2], weight[3*r+2]);
  end

  // Stage 2: registered row sums.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      for (int r = 0; r < 3; r++) row_sum_q[r] <= '0;
      sum_ok   <= 1'b0;
      sum_last <= 1'b0;
    end else if (bus.iSTART) begin
      for (int r = 0; r < 3; r++) row_sum_q[r] <= '0;
      sum_ok   <= 1'b0;
      sum_last <= 1'b0;
    end else begin
      for (int r = 0; r < 3; r++) row_sum_q[r] <= row_sum[r];
      sum_ok   <= win_ok;
      sum_last <= win_last;
    end
  end

  always_comb begin
    total = OWL'(row_sum_q[0]) + OWL'(row_sum_q[1]) + OWL'(row_sum_q[2]);
`ifdef BWN_RELU_EN
    total_out = total[OWL-1] ? '0 : total;
`else
    total_out = total;
`endif
  end

  // Stage 3: output register; oSUM holds between valid windows.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      bus.oSUM        <= '0;
      bus.oVALID      <= 1'b0;
      bus.oFRAME_DONE <= 1'b0;
    end else if (bus.iSTART) begin
      bus.oSUM        <= '0;
      bus.oVALID      <= 1'b0;
      bus.oFRAME_DONE <= 1'b0;
    end else begin
      bus.oVALID      <= sum_ok;
      bus.oFRAME_DONE <= sum_ok && sum_last;
      if (sum_ok)
        bus.oSUM <= total_out;
    end
  end
endmodule
